alu_mul_seq: RTL and testbench
==============================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have parameter W, default 8, data width; 8 is the only supported value, matching the ALU LSH/RSH bit slicing.
REQ-002 The block SHALL have port Clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port MulA, input, W, multiplicand; captured when Start is accepted.
REQ-006 The block SHALL have port MulB, input, W, multiplier; captured when Start is accepted.
REQ-007 The block SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port Done, output, 1, high for exactly one cycle, in DONE.
REQ-009 The block SHALL have port Product, output, W, (MulA*MulB) mod 2^W; held from DONE until the next accepted Start.
REQ-010 The block SHALL have port AluA, output, W, ALU InputA; combinational from state and registers.
REQ-011 The block SHALL have port AluB, output, W, ALU InputB; combinational.
REQ-012 The block SHALL have port AluOp, output, 4, ALU OP; combinational, encodings from the definitions package.
REQ-013 The block SHALL have port AluOut, input, W, ALU Out, consumed in the same cycle it is driven.

Function
REQ-014 The block SHALL implement states IDLE, ADD, LSH, RSH, DONE; registers acc, M, Q (each W bits).
REQ-015 In IDLE with Start=1, the block SHALL load acc=0, M=MulA, Q=MulB; next state: DONE if MulB==0, else ADD if MulB[0]==1, else LSH.
REQ-016 In IDLE with Start=0, the block SHALL remain in IDLE with all registers held.
REQ-017 In ADD, the block SHALL drive AluOp=ADD, AluA=acc, AluB=M, load acc<=AluOut (carry discarded), and go to LSH.
REQ-018 In LSH, the block SHALL drive AluOp=LSH, AluA=M, load M<=AluOut, and go to RSH.
REQ-019 In RSH, the block SHALL drive AluOp=RSH, AluA=Q, and load Q<=AluOut; next state: DONE if AluOut==0, else ADD if AluOut[0]==1, else LSH.
REQ-020 In DONE, the block SHALL assert Done, load Product<=acc, and return to IDLE.
REQ-021 Product SHALL be registered, with the value visible in the DONE cycle; an equivalent implementation is Product driven from acc while in DONE and registered thereafter.
REQ-022 In IDLE and DONE, the block SHALL drive AluOp=ADD with AluA=AluB=0.
REQ-023 In ADD, LSH and RSH, AluB SHALL be 0 except as stated in REQ-017.
REQ-024 Latency SHALL be as follows, for Start accepted at cycle T: Done is high at T+1+2k+p, where k is the index of the highest set bit of MulB plus 1 (0 if MulB==0) and p is popcount(MulB); the maximum is T+25.
REQ-025 Start SHALL be ignored while Busy=1, including in DONE; it is not queued.
REQ-026 Changes to MulA or MulB after acceptance SHALL have no effect on the operation in progress.
REQ-027 The block SHALL not use the ALU Zero output; the termination test uses AluOut in RSH.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE, acc=M=Q=0, Product=0, Done=0 and Busy=0, from any state.
REQ-029 Reset SHALL take priority over a simultaneous Start.
REQ-030 A multiply interrupted by Reset SHALL be abandoned, with no Done pulse.

Structure
REQ-031 The state enum mul_state_t {IDLE, ADD_S, LSH_S, RSH_S, DONE} SHALL be added to the shared definitions package, alongside the existing ALU op enum.
REQ-032 The ALU op encodings SHALL come only from that package; no local literals.
REQ-033 The block SHALL contain no sub-module; the ALU is instantiated beside it by the enclosing datapath or bench, wired AluA->InputA, AluB->InputB, AluOp->OP, Out->AluOut.

Verification
REQ-034 The bench SHALL instantiate alu_mul_seq together with the ALU and cover these directed scenarios:
- MulA=5, MulB=0, Start at T -> Done at T+1, Product=0x00.
- MulA=5, MulB=1 -> Done at T+4, Product=0x05; AluOp sequence ADD, LSH, RSH.
- MulA=0xFF, MulB=0xFF -> Done at T+25, Product=0x01; Busy high T+1..T+25.
- MulA=3, MulB=0x80 -> no ADD until the last iteration, Done at T+18, Product=0x80.
- Start pulsed again at T+3 of a MulB=6 job, and MulA changed mid-job -> ignored; single Done, Product=6*original MulA mod 256.
- Reset asserted at T+5 of a MulB=0xFF job -> next cycle IDLE, Busy=0, Product=0, no Done; a fresh 7*9 job then yields 0x3F.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the ALU and the sequential multiplier.
//   alu_op_t    : 4-bit ALU operation encodings (the only source of op codes)
//   mul_state_t : multiplier controller states
package alu_mul_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LSH = 4'd5,
    ALU_RSH = 4'd6
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_S = 3'd1,
    LSH_S = 3'd2,
    RSH_S = 3'd3,
    DONE  = 3'd4
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Small combinational ALU shared by the datapath; the multiplier drives it
// from outside (it is instantiated beside alu_mul_seq, not inside it).
// Ports:
//   InputA, InputB : operands (W bits)
//   OP             : operation, alu_op_t encoding
//   Out            : result (W bits, carry discarded)
//   Zero           : high when Out == 0
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic [3:0]   OP,
  output logic [W-1:0] Out,
  output logic         Zero
);

  always_comb begin
    Out = '0;
    case (alu_op_t'(OP))
      ALU_ADD: Out = InputA + InputB;
      ALU_SUB: Out = InputA - InputB;
      ALU_AND: Out = InputA & InputB;
      ALU_OR:  Out = InputA | InputB;
      ALU_XOR: Out = InputA ^ InputB;
      // Single-bit shifts, zero fill.
      ALU_LSH: Out = {InputA[W-2:0], 1'b0};
      ALU_RSH: Out = {1'b0, InputA[W-1:1]};
      default: Out = '0;
    endcase
  end

  assign Zero = (Out == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier controller that borrows an external ALU.
// Each iteration: optional ADD (acc += M when Q[0]), LSH (M <<= 1),
// RSH (Q >>= 1). It ends as soon as Q becomes zero, so latency depends on
// the multiplier's highest set bit and popcount.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   Start, MulA, MulB   : request and operands (sampled only in IDLE)
//   Busy, Done, Product : status, one-cycle completion pulse, W-bit result
//   AluA, AluB, AluOp   : drive the external ALU (combinational)
//   AluOut              : ALU result, consumed in the same cycle
// Handshake: a request is taken on a rising edge where Start=1 and Busy=0;
// while Busy=1 Start is ignored and not queued. Done pulses for one cycle
// with Product valid; Product then holds until the next completion.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] MulA,
  input  logic [W-1:0] MulB,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Product,
  output logic [W-1:0] AluA,
  output logic [W-1:0] AluB,
  output logic [3:0]   AluOp,
  input  logic [W-1:0] AluOut
);

  mul_state_t   state, state_next;
  logic [W-1:0] acc, m, q, product_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (MulB == '0)  state_next = DONE;
          else if (MulB[0]) state_next = ADD_S;
          else              state_next = LSH_S;
        end
      end
      ADD_S: state_next = LSH_S;
      LSH_S: state_next = RSH_S;
      // AluOut is the shifted multiplier: empty means nothing left to add.
      RSH_S: begin
        if (AluOut == '0)   state_next = DONE;
        else if (AluOut[0]) state_next = ADD_S;
        else                state_next = LSH_S;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy  = 1'b1;
    Done  = 1'b0;
    AluOp = ALU_ADD;
    AluA  = '0;
    AluB  = '0;
    case (state)
      IDLE:  Busy = 1'b0;
      ADD_S: begin
        AluOp = ALU_ADD;
        AluA  = acc;
        AluB  = m;
      end
      LSH_S: begin
        AluOp = ALU_LSH;
        AluA  = m;
      end
      RSH_S: begin
        AluOp = ALU_RSH;
        AluA  = q;
      end
      DONE:    Done = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc       <= '0;
      m         <= '0;
      q         <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            acc <= '0;
            m   <= MulA;
            q   <= MulB;
          end
        end
        ADD_S:   acc       <= AluOut;
        LSH_S:   m         <= AluOut;
        RSH_S:   q         <= AluOut;
        DONE:    product_q <= acc;
        default: ;
      endcase
    end
  end

  // Result is visible during DONE straight from acc, registered afterwards.
  assign Product = (state == DONE) ? acc : product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq wired to the companion ALU.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  localparam int W = 8;

  // Clock / reset
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] mul_a, mul_b;
  logic         busy, done;
  logic [W-1:0] product, alu_a, alu_b, alu_out;
  logic [3:0]   alu_op;
  logic         alu_zero;

  always #5 clk = ~clk;

  alu_mul_seq #(.W(W)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .MulA(mul_a), .MulB(mul_b),
    .Busy(busy), .Done(done), .Product(product),
    .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op), .AluOut(alu_out)
  );

  alu_mul_seq_alu #(.W(W)) u_alu (
    .InputA(alu_a), .InputB(alu_b), .OP(alu_op), .Out(alu_out), .Zero(alu_zero)
  );

  int tests = 0;
  int failed = 0;
  int done_count = 0;
  logic [3:0] op_log[$];

  always @(negedge clk) if (done) done_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: product and latency from the arithmetic rules.
  function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = (int'(a) * int'(b)) % 256;
    return W'(p);
  endfunction

  function automatic int model_lat(input logic [W-1:0] b);
    int k;
    k = 0;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return 1 + 2 * k + $countones(b);
  endfunction

  // Driver: issue one job, return Done latency, Product at Done, Busy sanity.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] prod, output bit busy_ok);
    int n;
    n = 0;
    busy_ok = 1'b1;
    prod = '0;
    op_log.delete();
    @(negedge clk);
    start = 1'b1; mul_a = a; mul_b = b;
    @(posedge clk);
    #1 start = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      op_log.push_back(alu_op);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        prod = product;
        break;
      end
      if (n > 40) begin
        $display("FAIL timeout: no Done after %0d cycles", n);
        failed++;
        break;
      end
    end
    lat = n;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] prod;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic [W-1:0] prod;
    bit busy_ok;
    int dc;
    int add_cnt;

    vecs[0] = '{8'h05, 8'h00, 8'h00, 1};
    vecs[1] = '{8'h05, 8'h01, 8'h05, 4};
    vecs[2] = '{8'hFF, 8'hFF, 8'h01, 25};
    vecs[3] = '{8'h03, 8'h80, 8'h80, 18};
    vecs[4] = '{8'h10, 8'h10, 8'h00, 12};
    vecs[5] = '{8'h0C, 8'h0B, 8'h84, 12};

    reset = 1'b1; start = 1'b0; mul_a = '0; mul_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_product", 32'(product), 0);
    check("idle_aluop", 32'(alu_op), 32'(ALU_ADD));
    check("idle_alua", 32'(alu_a), 0);
    check("idle_alub", 32'(alu_b), 0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].a, vecs[i].b, lat, prod, busy_ok);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_product", i), 32'(prod), 32'(vecs[i].prod));
      check($sformatf("vec%0d_busy", i), 32'(busy_ok), 1);
      if (i == 1) begin
        check("mulb1_op0", 32'(op_log[0]), 32'(ALU_ADD));
        check("mulb1_op1", 32'(op_log[1]), 32'(ALU_LSH));
        check("mulb1_op2", 32'(op_log[2]), 32'(ALU_RSH));
      end
      if (i == 3) begin
        add_cnt = 0;
        for (int j = 0; j < lat - 1; j++) if (op_log[j] == ALU_ADD) add_cnt++;
        check("mulb80_add_count", 32'(add_cnt), 1);
        check("mulb80_last_add", 32'(op_log[lat - 4]), 32'(ALU_ADD));
      end
      @(negedge clk);
      check($sformatf("vec%0d_done_drop", i), 32'(done), 0);
      check($sformatf("vec%0d_idle_busy", i), 32'(busy), 0);
      check($sformatf("vec%0d_product_hold", i), 32'(product), 32'(vecs[i].prod));
    end

    // Start re-pulsed mid-job and operands changed: ignored.
    dc = done_count;
    @(negedge clk);
    start = 1'b1; mul_a = 8'd9; mul_b = 8'd6;
    @(posedge clk);
    #1 start = 1'b0; mul_a = 8'd200;
    repeat (3) @(negedge clk);
    start = 1'b1; mul_b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("midjob_latency", 32'(lat), 32'(model_lat(8'd6)));
    check("midjob_product", 32'(product), 32'(model_prod(8'd9, 8'd6)));
    repeat (30) @(negedge clk);
    check("midjob_single_done", 32'(done_count - dc), 1);
    check("midjob_idle", 32'(busy), 0);

    // Start held through DONE: second edge must not launch another job.
    dc = done_count;
    start = 1'b1; mul_a = 8'd5; mul_b = 8'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_done_ignored", 32'(done_count - dc), 1);
    check("start_in_done_busy", 32'(busy), 0);

    // Reset mid-job: abandoned, no Done, Product cleared.
    dc = done_count;
    start = 1'b1; mul_a = 8'h11; mul_b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_product", 32'(product), 0);
    check("rst_done", 32'(done), 0);
    repeat (30) @(negedge clk);
    check("rst_no_done", 32'(done_count - dc), 0);

    // Reset wins over a simultaneous Start.
    reset = 1'b1; start = 1'b1; mul_a = 8'd3; mul_b = 8'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio_busy", 32'(busy), 0);

    run_job(8'd7, 8'd9, lat, prod, busy_ok);
    check("after_rst_product", 32'(prod), 32'h3F);
    check("after_rst_latency", 32'(lat), 32'(model_lat(8'd9)));

    // Randomized jobs against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_job(ra, rb, lat, prod, busy_ok);
      check($sformatf("rnd%0d_product a=%0h b=%0h", i, ra, rb), 32'(prod), 32'(model_prod(ra, rb)));
      check($sformatf("rnd%0d_latency b=%0h", i, rb), 32'(lat), 32'(model_lat(rb)));
      check($sformatf("rnd%0d_busy", i), 32'(busy_ok), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
